// File: rtl/tlb_ctrl_pkg.sv
// rtl/tlb_ctrl_pkg.sv - TLB geometry, entry layout, opcodes and FSM states shared with the MMU
package tlb_ctrl_pkg;
  localparam int TLB_NR_ENTRY           = 16;
  localparam int TLB_INDEX_WIDTH        = $clog2(TLB_NR_ENTRY);
  localparam int TLB_ENTRY_WIDTH        = 63;
  localparam int TLB_WRITE_STRUCT_WIDTH = 1 + TLB_INDEX_WIDTH + TLB_ENTRY_WIDTH;

  localparam int TLB_VPN2_W   = 19;
  localparam int TLB_LO_W     = 22;
  localparam int TLB_LO0_LSB  = 0;
  localparam int TLB_LO1_LSB  = 22;
  localparam int TLB_VPN2_LSB = 44;

  typedef enum logic [1:0] {
    TLB_OP_TLBWI = 2'b00,
    TLB_OP_TLBWR = 2'b01,
    TLB_OP_TLBP  = 2'b10,
    TLB_OP_TLBR  = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    TLB_ST_IDLE  = 2'b00,
    TLB_ST_WRITE = 2'b01,
    TLB_ST_PROBE = 2'b10,
    TLB_ST_READ  = 2'b11
  } tlb_state_e;
endpackage

// File: rtl/tlb_random.sv
// rtl/tlb_random.sv - Random index counter, decrements each cycle and wraps at wired_i
module tlb_random #(
  parameter  int NR_ENTRY = 16,
  localparam int IDXW     = $clog2(NR_ENTRY)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] wired_i,
  output logic [IDXW-1:0] random_o
);
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NR_ENTRY - 1);

  logic [IDXW-1:0] random_q, random_d;

  // wired_i = TOP_IDX makes the wrap condition permanently true, pinning Random at the top
  assign random_d = (random_q <= wired_i) ? TOP_IDX : random_q - IDXW'(1);
  assign random_o = random_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) random_q <= TOP_IDX;
    else      random_q <= random_d;
  end
endmodule

// File: rtl/tlb_ctrl.sv
// rtl/tlb_ctrl.sv - TLB write/probe/read controller with mirror array; TLB_PROBE_PARALLEL_EN selects one-cycle probe
module tlb_ctrl #(
  parameter  int TLB_NR_ENTRY = tlb_ctrl_pkg::TLB_NR_ENTRY,
  localparam int IDXW         = $clog2(TLB_NR_ENTRY)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         cmd_valid,
  input  logic [1:0]                                   cmd_op,
  output logic                                         busy,
  output logic                                         done,
  input  logic [18:0]                                  entryhi_i,
  input  logic [21:0]                                  entrylo0_i,
  input  logic [21:0]                                  entrylo1_i,
  input  logic [IDXW-1:0]                              index_i,
  input  logic [IDXW-1:0]                              wired_i,
  output logic [IDXW+tlb_ctrl_pkg::TLB_ENTRY_WIDTH:0]  tlb_write_struct,
  output logic [IDXW:0]                                probe_o,
  output logic [IDXW-1:0]                              random_o,
  output logic [18:0]                                  entryhi_o,
  output logic [21:0]                                  entrylo0_o,
  output logic [21:0]                                  entrylo1_o
);
  import tlb_ctrl_pkg::*;

  tlb_state_e                 state_q;
  tlb_op_e                    op;
  logic [TLB_ENTRY_WIDTH-1:0] mirror_q [TLB_NR_ENTRY];
  logic [TLB_NR_ENTRY-1:0]    written_q;
  logic [TLB_ENTRY_WIDTH-1:0] new_entry, rd_entry;
  logic [IDXW-1:0]            wr_idx;
  logic                       accept, is_write;

  tlb_random #(.NR_ENTRY(TLB_NR_ENTRY)) u_random (
    .clk      (clk),
    .rst      (rst),
    .wired_i  (wired_i),
    .random_o (random_o)
  );

  assign op        = tlb_op_e'(cmd_op);
  assign accept    = (state_q == TLB_ST_IDLE) && cmd_valid;
  assign is_write  = (op == TLB_OP_TLBWI) || (op == TLB_OP_TLBWR);
  assign wr_idx    = (op == TLB_OP_TLBWR) ? random_o : index_i;
  assign new_entry = {entryhi_i, entrylo1_i, entrylo0_i};
  assign rd_entry  = written_q[index_i] ? mirror_q[index_i] : '0;

`ifdef TLB_PROBE_PARALLEL_EN
  logic            par_hit;
  logic [IDXW-1:0] par_idx;

  // Walk downwards so the lowest matching index is the one left standing
  always_comb begin
    par_hit = 1'b0;
    par_idx = '0;
    for (int i = TLB_NR_ENTRY - 1; i >= 0; i--) begin
      if (written_q[i] && (mirror_q[i][TLB_VPN2_LSB +: TLB_VPN2_W] == entryhi_i)) begin
        par_hit = 1'b1;
        par_idx = IDXW'(i);
      end
    end
  end
`else
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLB_NR_ENTRY - 1);

  logic [IDXW-1:0]       scan_idx_q;
  logic [TLB_VPN2_W-1:0] scan_vpn_q;
  logic                  first_hit, scan_hit;

  // Entry 0 is checked in the acceptance cycle so a hit at k completes k+1 cycles later
  assign first_hit = written_q[0] && (mirror_q[0][TLB_VPN2_LSB +: TLB_VPN2_W] == entryhi_i);
  assign scan_hit  = written_q[scan_idx_q] &&
                     (mirror_q[scan_idx_q][TLB_VPN2_LSB +: TLB_VPN2_W] == scan_vpn_q);
`endif

  always_ff @(posedge clk) begin
    if (accept && is_write) mirror_q[wr_idx] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= TLB_ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      tlb_write_struct <= '0;
      probe_o          <= {1'b1, {IDXW{1'b0}}};
      written_q        <= '0;
      entryhi_o        <= '0;
      entrylo0_o       <= '0;
      entrylo1_o       <= '0;
`ifndef TLB_PROBE_PARALLEL_EN
      scan_idx_q       <= '0;
      scan_vpn_q       <= '0;
`endif
    end else if (state_q == TLB_ST_IDLE) begin
      if (cmd_valid) begin
        busy <= 1'b1;
        done <= 1'b1;
        case (op)
          TLB_OP_TLBWI, TLB_OP_TLBWR: begin
            state_q           <= TLB_ST_WRITE;
            tlb_write_struct  <= {1'b1, wr_idx, new_entry};
            written_q[wr_idx] <= 1'b1;
          end
          TLB_OP_TLBR: begin
            state_q    <= TLB_ST_READ;
            entryhi_o  <= rd_entry[TLB_VPN2_LSB +: TLB_VPN2_W];
            entrylo1_o <= rd_entry[TLB_LO1_LSB +: TLB_LO_W];
            entrylo0_o <= rd_entry[TLB_LO0_LSB +: TLB_LO_W];
          end
          default: begin
            state_q <= TLB_ST_PROBE;
`ifdef TLB_PROBE_PARALLEL_EN
            probe_o <= par_hit ? {1'b0, par_idx} : {1'b1, probe_o[IDXW-1:0]};
`else
            scan_vpn_q <= entryhi_i;
            scan_idx_q <= IDXW'(1);
            if (first_hit) probe_o <= {1'b0, {IDXW{1'b0}}};
            else           done    <= 1'b0;
`endif
          end
        endcase
      end
    end else if (done) begin
      state_q          <= TLB_ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      tlb_write_struct <= '0;
    end
`ifndef TLB_PROBE_PARALLEL_EN
    else if (state_q == TLB_ST_PROBE) begin
      if (scan_hit) begin
        done    <= 1'b1;
        probe_o <= {1'b0, scan_idx_q};
      end else if (scan_idx_q == LAST_IDX) begin
        done    <= 1'b1;
        probe_o <= {1'b1, probe_o[IDXW-1:0]};
      end else begin
        scan_idx_q <= scan_idx_q + IDXW'(1);
      end
    end
`endif
  end
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb/tb_tlb_ctrl.sv - self-checking bench for tlb_ctrl against a transaction-level model
module tb_tlb_ctrl;
  localparam int NR = 16;
  localparam int IW = $clog2(NR);
`ifdef TLB_PROBE_PARALLEL_EN
  localparam int HIT5_LAT = 1;
  localparam int MISS_LAT = 1;
`else
  localparam int HIT5_LAT = 6;
  localparam int MISS_LAT = NR;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid;
  logic [1:0] cmd_op;
  logic busy, done;
  logic [18:0] entryhi_i, entryhi_o;
  logic [21:0] entrylo0_i, entrylo1_i, entrylo0_o, entrylo1_o;
  logic [IW-1:0] index_i, wired_i, random_o;
  logic [IW+63:0] tlb_write_struct;
  logic [IW:0] probe_o;

  always #5 clk = ~clk;

  tlb_ctrl #(.TLB_NR_ENTRY(NR)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .busy(busy), .done(done), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
    .entrylo1_i(entrylo1_i), .index_i(index_i), .wired_i(wired_i),
    .tlb_write_struct(tlb_write_struct), .probe_o(probe_o), .random_o(random_o),
    .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a command occupies cycles N+1..N+lat after acceptance at N
  bit          m_wr [NR];
  logic [18:0] m_hi [NR];
  logic [21:0] m_l0 [NR];
  logic [21:0] m_l1 [NR];
  int          m_rand, m_pidx, m_pp_idx, m_j, m_lat;
  logic        m_p, m_pp_p;
  bit          m_isw;
  logic [IW+63:0] m_ws;
  logic [18:0] m_rhi;
  logic [21:0] m_rl0, m_rl1;

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_wr[i] = 0;
    m_rand = NR - 1; m_p = 1'b1; m_pidx = 0; m_j = 0; m_lat = 1; m_isw = 0;
    m_rhi = '0; m_rl0 = '0; m_rl1 = '0;
  endtask

  task automatic m_accept();
    int idx, k;
    m_isw = 0; m_lat = 1; m_j = 1;
    if (cmd_op == 2'b00 || cmd_op == 2'b01) begin
      idx = (cmd_op == 2'b01) ? m_rand : int'(index_i);
      m_isw = 1;
      m_wr[idx] = 1; m_hi[idx] = entryhi_i; m_l0[idx] = entrylo0_i; m_l1[idx] = entrylo1_i;
      m_ws = {1'b1, IW'(idx), entryhi_i, entrylo1_i, entrylo0_i};
    end else if (cmd_op == 2'b11) begin
      idx = int'(index_i);
      m_rhi = m_wr[idx] ? m_hi[idx] : '0;
      m_rl0 = m_wr[idx] ? m_l0[idx] : '0;
      m_rl1 = m_wr[idx] ? m_l1[idx] : '0;
    end else begin
      k = -1;
      for (int i = 0; i < NR; i++) if (k < 0 && m_wr[i] && m_hi[i] == entryhi_i) k = i;
      m_pp_p = (k < 0);
      m_pp_idx = (k < 0) ? m_pidx : k;
`ifdef TLB_PROBE_PARALLEL_EN
      m_lat = 1;
`else
      m_lat = (k < 0) ? NR : k + 1;
`endif
      if (m_lat == 1) begin m_p = m_pp_p; m_pidx = m_pp_idx; end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else begin
      if (m_j > 0) begin
        if (m_j == m_lat) m_j = 0;
        else begin
          m_j++;
          if (m_j == m_lat) begin m_p = m_pp_p; m_pidx = m_pp_idx; end
        end
      end else if (cmd_valid) m_accept();
      m_rand = (m_rand <= int'(wired_i)) ? NR - 1 : m_rand - 1;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_j > 0);
    check("done", done, m_j > 0 && m_j == m_lat);
    check("we", tlb_write_struct[IW+63], m_j == 1 && m_isw);
    if (m_j == 1 && m_isw) check("write_struct", tlb_write_struct, m_ws);
    check("random", random_o, m_rand);
    check("probe", probe_o, {m_p, IW'(m_pidx)});
    check("rd_entryhi", entryhi_o, m_rhi);
    check("rd_entrylo0", entrylo0_o, m_rl0);
    check("rd_entrylo1", entrylo1_o, m_rl1);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic issue(input logic [1:0] op, input int idx, input logic [18:0] hi,
                       input logic [21:0] l0, input logic [21:0] l1);
    cmd_op = op; index_i = IW'(idx); entryhi_i = hi; entrylo0_i = l0; entrylo1_i = l1;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = j; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); step(); rst = 1'b1;
  endtask

  initial begin
    int lat;
    bit saw_done;
    logic [IW+63:0] exp_ws;
    cmd_valid = 0; cmd_op = 0; entryhi_i = 0; entrylo0_i = 0; entrylo1_i = 0;
    index_i = 0; wired_i = IW'(4);
    step(); step(); step();
    rst = 1'b1;

    // Random sequence with wired=4, and TLBWR issued while Random is 9
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("rand_seq", random_o, (t < 12) ? 15 - t : 27 - t);
      if (t == 6) begin
        cmd_op = 2'b01; entryhi_i = 19'h00777; cmd_valid = 1'b1;
      end
      if (t == 7) begin
        check("tlbwr_we", tlb_write_struct[IW+63], 1'b1);
        check("tlbwr_index", tlb_write_struct[IW+62:63], 9);
        cmd_valid = 1'b0;
      end
    end
    wired_i = '0;
    step();

    // TLBWI payload and single-cycle we
    do_reset();
    issue(2'b00, 3, 19'h12345, 22'h3FFFFF, 22'h000002);
    @(negedge clk);
    exp_ws = {1'b1, 4'd3, 19'h12345, 22'h000002, 22'h3FFFFF};
    check("tlbwi_struct", tlb_write_struct, exp_ws);
    check("tlbwi_done", done, 1'b1);
    step();
    @(negedge clk);
    check("tlbwi_we_one_cycle", tlb_write_struct[IW+63], 1'b0);
    step();

    // Probe hit picks lowest of two matching indices
    issue(2'b00, 5, 19'h00AAA, 22'h1, 22'h2); step();
    issue(2'b00, 9, 19'h00AAA, 22'h3, 22'h4); step();
    issue(2'b10, 0, 19'h00AAA, 22'h0, 22'h0);
    wait_done(lat);
    check("probe_hit_latency", lat, HIT5_LAT);
    check("probe_hit_value", probe_o, 5'h05);
    step();

    // Probe miss after reset
    do_reset();
    issue(2'b10, 0, 19'h00000, 22'h0, 22'h0);
    wait_done(lat);
    check("probe_miss_latency", lat, MISS_LAT);
    check("probe_miss_p", probe_o[IW], 1'b1);
    step();

    // Reset in the middle of a probe scan
    issue(2'b00, 5, 19'h00AAA, 22'h1, 22'h2); step();
    issue(2'b00, 9, 19'h00AAA, 22'h3, 22'h4); step();
    issue(2'b10, 0, 19'h00AAA, 22'h0, 22'h0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_we", tlb_write_struct[IW+63], 1'b0);
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1;
    end
    check("abort_no_done", saw_done, 1'b0);
    step();
    rst = 1'b1;
    issue(2'b11, 5, 19'h0, 22'h0, 22'h0);
    @(negedge clk);
    check("abort_read_hi", entryhi_o, 19'h0);
    check("abort_read_lo0", entrylo0_o, 22'h0);
    check("abort_read_lo1", entrylo1_o, 22'h0);
    check("abort_read_done", done, 1'b1);
    step();

    // Command presented while busy is dropped
    issue(2'b10, 0, 19'h00055, 22'h0, 22'h0);
    cmd_op = 2'b00; index_i = IW'(7); entryhi_i = 19'h00777; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (20) step();
    issue(2'b11, 7, 19'h0, 22'h0, 22'h0);
    @(negedge clk);
    check("dropped_read_hi", entryhi_o, 19'h0);
    step();

    // Randomized traffic including dropped commands, wired changes and resets
    for (int c = 0; c < 900; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op = 2'($urandom);
      entryhi_i = 19'($urandom_range(0, 3));
      index_i = IW'($urandom);
      entrylo0_i = 22'($urandom);
      entrylo1_i = 22'($urandom);
      if ($urandom_range(0, 49) == 0) wired_i = IW'($urandom);
      step();
    end
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 Parameter TLB_NR_ENTRY, default 16: number of TLB entries; the index width is log2(TLB_NR_ENTRY).
REQ-002 clk  in  1: rising-edge clock. The MMU samples tlb_write_struct on the falling edge.
REQ-003 rst  in  1: reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1: command request, sampled only in IDLE.
REQ-005 cmd_op  in  2: command opcode; 00 = TLBWI, 01 = TLBWR, 10 = TLBP, 11 = TLBR.
REQ-006 busy  out  1: high from the cycle after acceptance through the cycle done is high.
REQ-007 done  out  1: one-cycle completion pulse.
REQ-008 entryhi_i  in  19: VPN2 used by TLBP and by writes.
REQ-009 entrylo0_i, entrylo1_i  in  22 each: {PFN[19:0], D, V}.
REQ-010 index_i  in  IDXW: target index for TLBWI and TLBR.
REQ-011 wired_i  in  IDXW: lower bound of the Random counter.
REQ-012 tlb_write_struct  out  1+IDXW+63: {we, index, entry}, with entry = {VPN2[62:44], lo1[43:22], lo0[21:0]}.
REQ-013 probe_o  out  1+IDXW: {P (1 = miss), index}.
REQ-014 random_o  out  IDXW: current Random value.
REQ-015 entryhi_o  out  19, entrylo0_o  out  22, entrylo1_o  out  22: TLBR results.

Function
REQ-016 The block SHALL keep a mirror array of TLB_NR_ENTRY entries, each with a "written" flag; the block is the only writer of the MMU TLB.
REQ-017 The FSM SHALL have the states IDLE, WRITE, PROBE and READ; a command is accepted when state = IDLE and cmd_valid = 1.
REQ-018 cmd_valid SHALL be ignored outside IDLE; such commands are dropped and leave no side effects.
REQ-019 TLBWI accepted in cycle N SHALL drive we = 1 with index = index_i for exactly cycle N+1, update the mirror in the same cycle, and assert done in N+1.
REQ-020 TLBWR SHALL behave as TLBWI, using the random_o value latched in the acceptance cycle as the index.
REQ-021 TLBR accepted in cycle N SHALL register entryhi_o, entrylo0_o and entrylo1_o from mirror[index_i] at N+1 and assert done at N+1.
REQ-022 An unwritten entry SHALL read as all zeros.
REQ-023 TLBP SHALL match entryhi_i against the VPN2 of written entries only.
REQ-024 On a TLBP hit, probe_o SHALL be {0, lowest matching index}.
REQ-025 On a TLBP miss, probe_o SHALL be {1, previous index bits}.
REQ-026 In all other cycles, probe_o SHALL hold its value.
REQ-027 Random SHALL decrement every cycle except during reset.
REQ-028 When Random equals wired_i, or is below it, the next Random value SHALL be TLB_NR_ENTRY-1.
REQ-029 When wired_i = TLB_NR_ENTRY-1, Random SHALL remain constant at TLB_NR_ENTRY-1.
REQ-030 we SHALL be high only in the WRITE state; the write payload SHALL be registered and stable for the whole cycle.
REQ-031 Inputs other than cmd_valid SHALL be sampled at acceptance and are don't-care afterwards, except for the PROBE scan, which uses the latched VPN2.

Reset
REQ-032 When rst is low, the block SHALL immediately clear state to IDLE, busy to 0, done to 0, we to 0 and tlb_write_struct to 0.
REQ-033 Reset SHALL also set probe_o to {1, 0} and Random to TLB_NR_ENTRY-1, and clear all written flags and the read outputs.
REQ-034 A reset that occurs during WRITE or PROBE SHALL abort the operation with no done pulse; we SHALL deassert asynchronously.

Configuration
REQ-035 The configuration macro SHALL be TLB_PROBE_PARALLEL_EN.
REQ-036 With TLB_PROBE_PARALLEL_EN defined, TLBP SHALL compare all entries in one cycle: accepted at N, probe_o valid and done at N+1.
REQ-037 Without TLB_PROBE_PARALLEL_EN, the PROBE state SHALL scan one entry per cycle from index 0.
REQ-038 In scan mode, a hit at index k SHALL finish with done at N+k+1; a miss SHALL finish with done at N+TLB_NR_ENTRY.
REQ-039 Without TLB_PROBE_PARALLEL_EN, the scan counter SHALL stop at TLB_NR_ENTRY-1 and SHALL NOT wrap.

Structure
REQ-040 A shared package SHALL hold TLB_NR_ENTRY, TLB_INDEX_WIDTH, TLB_ENTRY_WIDTH (63), TLB_WRITE_STRUCT_WIDTH, the entry field offsets, the cmd_op encodings and the FSM state encodings, all shared with the MMU.
REQ-041 The sub-module tlb_random SHALL implement the Random counter with its wired_i wrap.

Verification
REQ-042 After reset, issue TLBWI with index_i=3, VPN2=0x12345, lo0=0x3FFFFF and lo1=0x000002 -> exactly one cycle with we=1, index=3, entry={0x12345, 0x000002, 0x3FFFFF}; done in the same cycle.
REQ-043 With wired_i=4, run 20 cycles after reset -> random_o follows the sequence 15, 14, ..., 4, 15, 14, ...; a TLBWR issued when random_o=9 writes index 9.
REQ-044 Write VPN2 0x00AAA to indices 5 and 9, then TLBP with 0x00AAA -> probe_o={0,5}; done at N+1 when parallel, N+6 when scanning.
REQ-045 TLBP with an unwritten VPN2 of 0 after reset -> probe_o P=1; done at N+1 when parallel, N+16 when scanning.
REQ-046 Assert rst low during the PROBE scan (cycle N+3) -> busy=0, we=0 and no done pulse; a subsequent TLBR of index 5 returns zeros.
REQ-047 Drive cmd_valid during busy -> no state or mirror change; the command is dropped.
